// File: rtl/hamming_scrub_if.sv
// Handshake bundle for hamming_scrub_decoder: codeword in, corrected codeword and flags out.
// The error counter ports exist only when HAMMING_SCRUB_ERR_CNT_EN is defined.
interface hamming_scrub_if #(
   parameter int width = 16
);
   localparam int blocks      = width / 4;
   localparam int parity_bits = blocks * 3;

   logic                   in_valid;
   logic                   in_ready;
   logic [width-1:0]       data_in;
   logic [parity_bits-1:0] parity_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [width-1:0]       data_out;
   logic [parity_bits-1:0] parity_out;
   logic [blocks-1:0]      err_data;
   logic [blocks-1:0]      err_parity;
   logic                   busy;
`ifdef HAMMING_SCRUB_ERR_CNT_EN
   logic [15:0]            err_count;
   logic                   err_count_clr;
`endif

`ifdef HAMMING_SCRUB_ERR_CNT_EN
   modport slave (
      input  in_valid, data_in, parity_in, out_ready, err_count_clr,
      output in_ready, out_valid, data_out, parity_out, err_data, err_parity, busy, err_count
   );
   modport master (
      output in_valid, data_in, parity_in, out_ready, err_count_clr,
      input  in_ready, out_valid, data_out, parity_out, err_data, err_parity, busy, err_count
   );
`else
   modport slave (
      input  in_valid, data_in, parity_in, out_ready,
      output in_ready, out_valid, data_out, parity_out, err_data, err_parity, busy
   );
   modport master (
      output in_valid, data_in, parity_in, out_ready,
      input  in_ready, out_valid, data_out, parity_out, err_data, err_parity, busy
   );
`endif
endinterface

// File: rtl/hamming_scrub_decoder.sv
// Per-nibble Hamming(7,4) single-error corrector for scrub write-back, one codeword in flight.
// Optional saturating corrected-nibble counter enabled by HAMMING_SCRUB_ERR_CNT_EN.
module hamming_scrub_decoder #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset,
   hamming_scrub_if.slave   bus
);
   localparam int blocks      = width / 4;
   localparam int parity_bits = blocks * 3;

   typedef enum logic [1:0] {IDLE, CHECK, CORRECT, DONE} state_t;

   state_t                 state_q;
   logic [width-1:0]       dataCap_q;
   logic [parity_bits-1:0] parityCap_q;
   logic [parity_bits-1:0] syndrome_q, syndrome_d;
   logic [width-1:0]       dataOut_q, dataOut_d;
   logic [parity_bits-1:0] parityOut_q, parityOut_d;
   logic [blocks-1:0]      errData_q, errData_d;
   logic [blocks-1:0]      errParity_q, errParity_d;
   logic                   outValid_q;
   logic                   inReady_q;
   logic                   busy_q;

   // Syndrome = stored parity XOR parity recomputed from the captured data nibble.
   always_comb begin
      syndrome_d = '0;
      for (int i = 0; i < blocks; i++) begin
         syndrome_d[i*3+2] = parityCap_q[i*3+2] ^ (dataCap_q[i*4] ^ dataCap_q[i*4+2] ^ dataCap_q[i*4+3]);
         syndrome_d[i*3+1] = parityCap_q[i*3+1] ^ (dataCap_q[i*4] ^ dataCap_q[i*4+1] ^ dataCap_q[i*4+3]);
         syndrome_d[i*3+0] = parityCap_q[i*3+0] ^ (dataCap_q[i*4] ^ dataCap_q[i*4+1] ^ dataCap_q[i*4+2]);
      end
   end

   // Every nonzero syndrome names exactly one bit to flip; double errors are miscorrected.
   always_comb begin
      dataOut_d   = dataCap_q;
      parityOut_d = parityCap_q;
      errData_d   = '0;
      errParity_d = '0;
      for (int i = 0; i < blocks; i++) begin
         case (syndrome_q[i*3 +: 3])
            3'b111: begin dataOut_d[i*4+0]   = ~dataCap_q[i*4+0];   errData_d[i]   = 1'b1; end
            3'b011: begin dataOut_d[i*4+1]   = ~dataCap_q[i*4+1];   errData_d[i]   = 1'b1; end
            3'b101: begin dataOut_d[i*4+2]   = ~dataCap_q[i*4+2];   errData_d[i]   = 1'b1; end
            3'b110: begin dataOut_d[i*4+3]   = ~dataCap_q[i*4+3];   errData_d[i]   = 1'b1; end
            3'b001: begin parityOut_d[i*3+0] = ~parityCap_q[i*3+0]; errParity_d[i] = 1'b1; end
            3'b010: begin parityOut_d[i*3+1] = ~parityCap_q[i*3+1]; errParity_d[i] = 1'b1; end
            3'b100: begin parityOut_d[i*3+2] = ~parityCap_q[i*3+2]; errParity_d[i] = 1'b1; end
            default: ;
         endcase
      end
   end

`ifdef HAMMING_SCRUB_ERR_CNT_EN
   logic [15:0] errCount_q, errCount_d;
   logic [15:0] corrNibbles;
   logic [16:0] countSum;

   always_comb begin
      corrNibbles = '0;
      for (int i = 0; i < blocks; i++) begin
         corrNibbles = corrNibbles + 16'(errData_d[i] | errParity_d[i]);
      end
      countSum   = {1'b0, errCount_q} + {1'b0, corrNibbles};
      errCount_d = errCount_q;
      if (bus.err_count_clr) begin
         errCount_d = '0;
      end else if (state_q == CORRECT) begin
         errCount_d = countSum[16] ? 16'hFFFF : countSum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         errCount_q <= '0;
      end else begin
         errCount_q <= errCount_d;
      end
   end

   assign bus.err_count = errCount_q;
`endif

   // Control FSM; handshake outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         dataCap_q   <= '0;
         parityCap_q <= '0;
         syndrome_q  <= '0;
         dataOut_q   <= '0;
         parityOut_q <= '0;
         errData_q   <= '0;
         errParity_q <= '0;
         outValid_q  <= 1'b0;
         inReady_q   <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dataCap_q   <= bus.data_in;
                  parityCap_q <= bus.parity_in;
                  inReady_q   <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= CHECK;
               end
            end
            CHECK: begin
               syndrome_q <= syndrome_d;
               state_q    <= CORRECT;
            end
            CORRECT: begin
               dataOut_q   <= dataOut_d;
               parityOut_q <= parityOut_d;
               errData_q   <= errData_d;
               errParity_q <= errParity_d;
               outValid_q  <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = inReady_q;
   assign bus.out_valid  = outValid_q;
   assign bus.busy       = busy_q;
   assign bus.data_out   = dataOut_q;
   assign bus.parity_out = parityOut_q;
   assign bus.err_data   = errData_q;
   assign bus.err_parity = errParity_q;
endmodule
